// File: rtl/scu_dma_sched_pkg.sv
// -----------------------------------------------------------------------------
// scu_dma_sched_pkg
//   Shared types and constants for the SCU DMA channel scheduler.
//   dma_ft_t          : DxMD.FT start-factor encoding (0..6 = event, 7 = GO)
//   dma_sched_state_t : scheduler FSM states
//   dma_pri_enc()     : fixed-priority pick, lowest index wins
// -----------------------------------------------------------------------------
package scu_dma_sched_pkg;

  localparam int DMA_NCH  = 3;
  localparam int DMA_NEVT = 7;

  typedef enum logic [2:0] {
    FT_VBIN   = 3'd0,
    FT_VBOUT  = 3'd1,
    FT_HBIN   = 3'd2,
    FT_TM0    = 3'd3,
    FT_TM1    = 3'd4,
    FT_SND    = 3'd5,
    FT_SPREND = 3'd6,
    FT_GO     = 3'd7
  } dma_ft_t;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_REQ  = 2'd1,
    DS_BUSY = 2'd2
  } dma_sched_state_t;

  // Channel 0 has the highest priority; caller guarantees wt != 0.
  function automatic logic [1:0] dma_pri_enc(input logic [DMA_NCH-1:0] wt);
    if (wt[0])      dma_pri_enc = 2'd0;
    else if (wt[1]) dma_pri_enc = 2'd1;
    else            dma_pri_enc = 2'd2;
  endfunction

endpackage

// File: rtl/scu_dma_sched_trig.sv
// -----------------------------------------------------------------------------
// scu_dma_trig
//   Per-channel start-factor decode, pending (WT) latch and dropped-trigger flag.
//   Build option: SCU_DMA_TRIG_OVF_EN adds the sticky overflow flag; without it
//   trig_ovf is tied low.
// Ports
//   clk, rst, ce : clock, sync active-high reset, clock enable
//   en, go       : DxEN.EN level, DxEN.GO strobe
//   ft           : DxMD.FT start factor
//   evt          : start event pulses
//   dstp         : DSTP.STOP strobe (clears WT, drops triggers)
//   ack          : engine accepted this channel (WT -> MV handled by top)
//   done         : engine finished this channel this cycle
//   mv           : channel currently moving (from top)
//   wt           : channel pending
//   trig_ovf     : sticky dropped-trigger flag
// -----------------------------------------------------------------------------
module scu_dma_trig
  import scu_dma_sched_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                ce,
  input  logic                en,
  input  logic                go,
  input  logic [2:0]          ft,
  input  logic [DMA_NEVT-1:0] evt,
  input  logic                dstp,
  input  logic                ack,
  input  logic                done,
  input  logic                mv,
  output logic                wt,
  output logic                trig_ovf
);

  // GO sits at index 7 so the FT code indexes the source vector directly.
  logic [7:0] src;
  logic       trig;
  logic       accept;

  assign src    = {go, evt};
  assign trig   = ce & en & src[ft];
  // A trigger coincident with this channel's completion re-arms it.
  assign accept = trig & ((~wt & ~mv) | done);

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wt <= 1'b0;
    end else if (ce) begin
      if (dstp || ack || !en) wt <= 1'b0;
      else if (accept)        wt <= 1'b1;
    end
  end

`ifdef SCU_DMA_TRIG_OVF_EN
  logic drop;
  logic ovf_q;

  assign drop = trig & ~accept;

  // A drop wins over the GO clear so a GO that is itself dropped still flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (ce) begin
      if (dstp)      ovf_q <= 1'b0;
      else if (drop) ovf_q <= 1'b1;
      else if (go)   ovf_q <= 1'b0;
    end
  end

  assign trig_ovf = ovf_q;
`else
  assign trig_ovf = 1'b0;
`endif

endmodule

// File: rtl/scu_dma_sched.sv
// -----------------------------------------------------------------------------
// scu_dma_sched
//   Schedules SCU DMA channels D0..D2 onto the single transfer engine with
//   fixed priority D0 > D1 > D2. Holds the grant FSM, the MV bits and the
//   completion/abort pulses; per-channel trigger logic lives in scu_dma_trig.
//   Build option: SCU_DMA_TRIG_OVF_EN enables the TRIG_OVF sticky flags.
// Ports
//   clk, rst, ce         : clock, sync active-high reset, clock enable
//   dx_en, dx_go, dx_ft  : per-channel enable, GO strobe, start factor {FT2,FT1,FT0}
//   evt                  : start events [0]VBIN..[6]SPREND
//   dstp                 : stop-all strobe
//   eng_req, eng_ch      : grant to engine and granted channel
//   eng_ack, eng_done    : engine handshake
//   eng_abort            : one-cycle forced stop
//   dsta_ch, dsta_ddmv   : {D2WT,D2MV,D1WT,D1MV,D0WT,D0MV} and OR of MV
//   dend                 : per-channel completion pulse
//   trig_ovf             : sticky dropped-trigger flags
// -----------------------------------------------------------------------------
module scu_dma_sched
  import scu_dma_sched_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic [DMA_NCH-1:0]    dx_en,
  input  logic [DMA_NCH-1:0]    dx_go,
  input  logic [3*DMA_NCH-1:0]  dx_ft,
  input  logic [DMA_NEVT-1:0]   evt,
  input  logic                  dstp,
  output logic                  eng_req,
  output logic [1:0]            eng_ch,
  input  logic                  eng_ack,
  input  logic                  eng_done,
  output logic                  eng_abort,
  output logic [2*DMA_NCH-1:0]  dsta_ch,
  output logic                  dsta_ddmv,
  output logic [DMA_NCH-1:0]    dend,
  output logic [DMA_NCH-1:0]    trig_ovf
);

  dma_sched_state_t   state;
  logic [DMA_NCH-1:0] wt;
  logic [DMA_NCH-1:0] mv;
  logic [DMA_NCH-1:0] ack_ch;
  logic [DMA_NCH-1:0] done_ch;

  // Handshakes only count in the matching state; DSTP overrides a same-cycle DONE.
  always_comb begin
    // NOTE: defaults first so no latch is inferred on the untaken paths.
    ack_ch  = '0;
    done_ch = '0;
    if (state == DS_REQ && eng_ack)            ack_ch[eng_ch]  = 1'b1;
    if (state == DS_BUSY && eng_done && !dstp) done_ch[eng_ch] = 1'b1;
  end

  for (genvar i = 0; i < DMA_NCH; i++) begin : g_trig
    scu_dma_trig u_trig (
      .clk      (clk),
      .rst      (rst),
      .ce       (ce),
      .en       (dx_en[i]),
      .go       (dx_go[i]),
      .ft       (dx_ft[3*i +: 3]),
      .evt      (evt),
      .dstp     (dstp),
      .ack      (ack_ch[i]),
      .done     (done_ch[i]),
      .mv       (mv[i]),
      .wt       (wt[i]),
      .trig_ovf (trig_ovf[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= DS_IDLE;
      eng_req   <= 1'b0;
      eng_ch    <= 2'd0;
      eng_abort <= 1'b0;
      mv        <= '0;
      dend      <= '0;
    end else begin
      // Pulses last exactly one enabled cycle and stay low while CE=0.
      dend      <= '0;
      eng_abort <= 1'b0;
      if (ce) begin
        if (dstp) begin
          mv        <= '0;
          eng_req   <= 1'b0;
          eng_abort <= (state != DS_IDLE);
          state     <= DS_IDLE;
        end else begin
          case (state)
            DS_IDLE: begin
              if (|wt) begin
                eng_ch  <= dma_pri_enc(wt);
                eng_req <= 1'b1;
                state   <= DS_REQ;
              end
            end
            // Grant is held without re-arbitration until the engine takes it.
            DS_REQ: begin
              if (eng_ack) begin
                eng_req    <= 1'b0;
                mv[eng_ch] <= 1'b1;
                state      <= DS_BUSY;
              end
            end
            DS_BUSY: begin
              if (eng_done) begin
                mv[eng_ch]   <= 1'b0;
                dend[eng_ch] <= 1'b1;
                state        <= DS_IDLE;
              end
            end
            default: state <= DS_IDLE;
          endcase
        end
      end
    end
  end

  always_comb begin
    dsta_ch = '0;
    for (int i = 0; i < DMA_NCH; i++) begin
      dsta_ch[2*i]   = mv[i];
      dsta_ch[2*i+1] = wt[i];
    end
  end

  assign dsta_ddmv = |mv;

endmodule

// File: tb/tb_scu_dma_sched.sv
// -----------------------------------------------------------------------------
// tb_scu_dma_sched
//   Directed, table-driven bench for scu_dma_sched. Each record is one clock:
//   inputs applied before the edge, outputs compared on the following falling
//   edge. Hand-written sequences cover reset, grant latency and reset mid-run.
// -----------------------------------------------------------------------------
module tb_scu_dma_sched;

`ifdef SCU_DMA_TRIG_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       ce;
  logic [2:0] dx_en, dx_go;
  logic [8:0] dx_ft;
  logic [6:0] evt;
  logic       dstp;
  logic       eng_req;
  logic [1:0] eng_ch;
  logic       eng_ack, eng_done;
  logic       eng_abort;
  logic [5:0] dsta_ch;
  logic       dsta_ddmv;
  logic [2:0] dend;
  logic [2:0] trig_ovf;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  scu_dma_sched dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .dx_en     (dx_en),
    .dx_go     (dx_go),
    .dx_ft     (dx_ft),
    .evt       (evt),
    .dstp      (dstp),
    .eng_req   (eng_req),
    .eng_ch    (eng_ch),
    .eng_ack   (eng_ack),
    .eng_done  (eng_done),
    .eng_abort (eng_abort),
    .dsta_ch   (dsta_ch),
    .dsta_ddmv (dsta_ddmv),
    .dend      (dend),
    .trig_ovf  (trig_ovf)
  );

  typedef struct {
    string      name;
    logic       ce;
    logic [2:0] en;
    logic [2:0] go;
    logic [6:0] evt;
    logic       dstp;
    logic       ack;
    logic       done;
    logic       req;
    logic [1:0] ch;
    logic       abort;
    logic [5:0] dsta;
    logic [2:0] dend;
    logic [2:0] ovf;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(string name, bit ce, bit [2:0] en, bit [2:0] go,
                              bit [6:0] ev, bit sp, bit ak, bit dn,
                              bit rq, bit [1:0] ch, bit ab, bit [5:0] st,
                              bit [2:0] de, bit [2:0] ov);
    vec_t v;
    v.name = name; v.ce = ce; v.en = en; v.go = go; v.evt = ev; v.dstp = sp;
    v.ack = ak; v.done = dn; v.req = rq; v.ch = ch; v.abort = ab; v.dsta = st;
    v.dend = de; v.ovf = ov;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    ce = 1'b1; dx_go = '0; evt = '0; dstp = 1'b0; eng_ack = 1'b0; eng_done = 1'b0;
  endtask

  task automatic check_all_zero(string tag);
    check({tag, " req"},   32'(eng_req),   32'd0);
    check({tag, " abort"}, 32'(eng_abort), 32'd0);
    check({tag, " dsta"},  32'(dsta_ch),   32'd0);
    check({tag, " ddmv"},  32'(dsta_ddmv), 32'd0);
    check({tag, " dend"},  32'(dend),      32'd0);
    check({tag, " ovf"},   32'(trig_ovf),  32'd0);
  endtask

  initial begin
    int lat;
    // FT0 = GO, FT1 = FT2 = VBIN for the whole run.
    dx_ft = {3'd0, 3'd0, 3'd7};
    dx_en = 3'b111;
    idle_inputs();
    rst = 1'b1;

    //            name   ce en     go     evt  sp ak dn | rq ch ab dsta       dend    ovf
    vq.push_back(mk("t1_go",    1, 3'b111, 3'b001, 7'd0, 0, 0, 0, 0, 0, 0, 6'b000010, 3'b000, 3'b000));
    vq.push_back(mk("t1_req",   1, 3'b111, 3'b000, 7'd0, 0, 0, 0, 1, 0, 0, 6'b000010, 3'b000, 3'b000));
    vq.push_back(mk("t1_hold",  1, 3'b111, 3'b000, 7'd0, 0, 0, 0, 1, 0, 0, 6'b000010, 3'b000, 3'b000));
    vq.push_back(mk("t1_ack",   1, 3'b111, 3'b000, 7'd0, 0, 1, 0, 0, 0, 0, 6'b000001, 3'b000, 3'b000));
    vq.push_back(mk("t1_done",  1, 3'b111, 3'b000, 7'd0, 0, 0, 1, 0, 0, 0, 6'b000000, 3'b001, 3'b000));
    vq.push_back(mk("t1_idle",  1, 3'b111, 3'b000, 7'd0, 0, 0, 0, 0, 0, 0, 6'b000000, 3'b000, 3'b000));
    vq.push_back(mk("t2_evt",   1, 3'b111, 3'b000, 7'd1, 0, 0, 0, 0, 0, 0, 6'b101000, 3'b000, 3'b000));
    vq.push_back(mk("t2_req1",  1, 3'b111, 3'b000, 7'd0, 0, 0, 0, 1, 1, 0, 6'b101000, 3'b000, 3'b000));
    vq.push_back(mk("t2_ack1",  1, 3'b111, 3'b000, 7'd0, 0, 1, 0, 0, 1, 0, 6'b100100, 3'b000, 3'b000));
    vq.push_back(mk("t2_done1", 1, 3'b111, 3'b000, 7'd0, 0, 0, 1, 0, 1, 0, 6'b100000, 3'b010, 3'b000));
    vq.push_back(mk("t2_req2",  1, 3'b111, 3'b000, 7'd0, 0, 0, 0, 1, 2, 0, 6'b100000, 3'b000, 3'b000));
    vq.push_back(mk("t3_go0",   1, 3'b111, 3'b001, 7'd0, 0, 0, 0, 1, 2, 0, 6'b100010, 3'b000, 3'b000));
    vq.push_back(mk("t3_hold",  1, 3'b111, 3'b000, 7'd0, 0, 0, 0, 1, 2, 0, 6'b100010, 3'b000, 3'b000));
    vq.push_back(mk("t3_ack2",  1, 3'b111, 3'b000, 7'd0, 0, 1, 0, 0, 2, 0, 6'b010010, 3'b000, 3'b000));
    vq.push_back(mk("t3_done2", 1, 3'b111, 3'b000, 7'd0, 0, 0, 1, 0, 2, 0, 6'b000010, 3'b100, 3'b000));
    vq.push_back(mk("t3_req0",  1, 3'b111, 3'b000, 7'd0, 0, 0, 0, 1, 0, 0, 6'b000010, 3'b000, 3'b000));
    vq.push_back(mk("t3_ack0",  1, 3'b111, 3'b000, 7'd0, 0, 1, 0, 0, 0, 0, 6'b000001, 3'b000, 3'b000));
    vq.push_back(mk("t4_drop",  1, 3'b111, 3'b001, 7'd0, 0, 0, 0, 0, 0, 0, 6'b000001, 3'b000, 3'b001));
    vq.push_back(mk("t4_godn",  1, 3'b111, 3'b001, 7'd0, 0, 0, 1, 0, 0, 0, 6'b000010, 3'b001, 3'b000));
    vq.push_back(mk("t4_req",   1, 3'b111, 3'b000, 7'd0, 0, 0, 0, 1, 0, 0, 6'b000010, 3'b000, 3'b000));
    vq.push_back(mk("t4_ack",   1, 3'b111, 3'b000, 7'd0, 0, 1, 0, 0, 0, 0, 6'b000001, 3'b000, 3'b000));
    vq.push_back(mk("t5_done0", 1, 3'b111, 3'b000, 7'd0, 0, 0, 1, 0, 0, 0, 6'b000000, 3'b001, 3'b000));
    vq.push_back(mk("t5_evt",   1, 3'b111, 3'b000, 7'd1, 0, 0, 0, 0, 0, 0, 6'b101000, 3'b000, 3'b000));
    vq.push_back(mk("t5_req1",  1, 3'b111, 3'b000, 7'd0, 0, 0, 0, 1, 1, 0, 6'b101000, 3'b000, 3'b000));
    vq.push_back(mk("t5_ack1",  1, 3'b111, 3'b000, 7'd0, 0, 1, 0, 0, 1, 0, 6'b100100, 3'b000, 3'b000));
    vq.push_back(mk("t5_go0",   1, 3'b111, 3'b001, 7'd0, 0, 0, 0, 0, 1, 0, 6'b100110, 3'b000, 3'b000));
    vq.push_back(mk("t5_drop0", 1, 3'b111, 3'b001, 7'd0, 0, 0, 0, 0, 1, 0, 6'b100110, 3'b000, 3'b001));
    vq.push_back(mk("t5_dstp",  1, 3'b111, 3'b001, 7'd0, 1, 0, 0, 0, 1, 1, 6'b000000, 3'b000, 3'b000));
    vq.push_back(mk("t5_after", 1, 3'b111, 3'b000, 7'd0, 0, 0, 0, 0, 1, 0, 6'b000000, 3'b000, 3'b000));
    vq.push_back(mk("t6_evt",   1, 3'b111, 3'b000, 7'd1, 0, 0, 0, 0, 1, 0, 6'b101000, 3'b000, 3'b000));
    vq.push_back(mk("t6_req1",  1, 3'b111, 3'b000, 7'd0, 0, 0, 0, 1, 1, 0, 6'b101000, 3'b000, 3'b000));
    vq.push_back(mk("t6_ack1",  1, 3'b111, 3'b000, 7'd0, 0, 1, 0, 0, 1, 0, 6'b100100, 3'b000, 3'b000));
    vq.push_back(mk("t6_go0",   1, 3'b111, 3'b001, 7'd0, 0, 0, 0, 0, 1, 0, 6'b100110, 3'b000, 3'b000));
    vq.push_back(mk("t6_en0lo", 1, 3'b110, 3'b000, 7'd0, 0, 0, 0, 0, 1, 0, 6'b100100, 3'b000, 3'b000));
    vq.push_back(mk("t6_done1", 1, 3'b111, 3'b000, 7'd0, 0, 0, 1, 0, 1, 0, 6'b100000, 3'b010, 3'b000));
    vq.push_back(mk("t6_req2",  1, 3'b111, 3'b000, 7'd0, 0, 0, 0, 1, 2, 0, 6'b100000, 3'b000, 3'b000));
    vq.push_back(mk("t6_ack2",  1, 3'b111, 3'b000, 7'd0, 0, 1, 0, 0, 2, 0, 6'b010000, 3'b000, 3'b000));
    vq.push_back(mk("t6_ce0",   0, 3'b111, 3'b001, 7'd1, 0, 0, 1, 0, 2, 0, 6'b010000, 3'b000, 3'b000));
    vq.push_back(mk("t6_done2", 1, 3'b111, 3'b000, 7'd0, 0, 0, 1, 0, 2, 0, 6'b000000, 3'b100, 3'b000));
    vq.push_back(mk("t6_idle",  1, 3'b111, 3'b000, 7'd0, 0, 0, 0, 0, 2, 0, 6'b000000, 3'b000, 3'b000));
    vq.push_back(mk("t7_evt",   1, 3'b111, 3'b000, 7'd1, 0, 0, 0, 0, 2, 0, 6'b101000, 3'b000, 3'b000));
    vq.push_back(mk("t7_req1",  1, 3'b111, 3'b000, 7'd0, 0, 0, 0, 1, 1, 0, 6'b101000, 3'b000, 3'b000));
    vq.push_back(mk("t7_ack1",  1, 3'b111, 3'b000, 7'd0, 0, 1, 0, 0, 1, 0, 6'b100100, 3'b000, 3'b000));
    vq.push_back(mk("t7_stpdn", 1, 3'b111, 3'b000, 7'd0, 1, 0, 1, 0, 1, 1, 6'b000000, 3'b000, 3'b000));
    vq.push_back(mk("t7_after", 1, 3'b111, 3'b000, 7'd0, 0, 0, 0, 0, 1, 0, 6'b000000, 3'b000, 3'b000));
    vq.push_back(mk("t7_ignor", 1, 3'b111, 3'b000, 7'd0, 0, 1, 1, 0, 1, 0, 6'b000000, 3'b000, 3'b000));

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    check("reset ch", 32'(eng_ch), 32'd0);
    rst = 1'b0;

    foreach (vq[k]) begin
      ce = vq[k].ce; dx_en = vq[k].en; dx_go = vq[k].go; evt = vq[k].evt;
      dstp = vq[k].dstp; eng_ack = vq[k].ack; eng_done = vq[k].done;
      @(posedge clk);
      @(negedge clk);
      check({vq[k].name, " req"},   32'(eng_req),   32'(vq[k].req));
      check({vq[k].name, " ch"},    32'(eng_ch),    32'(vq[k].ch));
      check({vq[k].name, " abort"}, 32'(eng_abort), 32'(vq[k].abort));
      check({vq[k].name, " dsta"},  32'(dsta_ch),   32'(vq[k].dsta));
      check({vq[k].name, " ddmv"},  32'(dsta_ddmv),
            32'(vq[k].dsta[0] | vq[k].dsta[2] | vq[k].dsta[4]));
      check({vq[k].name, " dend"},  32'(dend),      32'(vq[k].dend));
      check({vq[k].name, " ovf"},   32'(trig_ovf),  32'(OVF_ON ? vq[k].ovf : 3'b000));
    end
    idle_inputs();
    dx_en = 3'b111;

    // Grant latency from a GO write: WT on the first edge, ENG_REQ on the second.
    dx_go = 3'b001;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      dx_go = '0;
    end while (!eng_req && lat < 10);
    check("lat cycles", 32'(lat), 32'd2);
    check("lat ch", 32'(eng_ch), 32'd0);

    // Reset while BUSY returns everything to zero.
    eng_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    eng_ack = 1'b0;
    check("busy mv0", 32'(dsta_ch), 32'b000001);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("midrst");
    check("midrst ch", 32'(eng_ch), 32'd0);
    eng_done = 1'b1;
    @(posedge clk);
    @(negedge clk);
    eng_done = 1'b0;
    check("midrst done ignored", 32'(dend), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
